// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register file block: default data/address
// widths and the state type of the clear sequencer.
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int N_DEF = 8;   // default data width
   localparam int A_DEF = 3;   // default address width (2^A registers)

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DONE
   } clr_state_t;

endpackage

// File: rtl/regfile_np_if.sv
// -----------------------------------------------------------------------------
// regfile_np_if
// Bus between a register file user (master) and regfile_np (slave).
//   we, waddr, wdata   : dedicated write port
//   raddr1/2, rdata1/2 : two combinational read ports
//   clr_req            : request to zero the whole file
//   busy, clr_done     : clear sequence running / one-cycle completion pulse
// -----------------------------------------------------------------------------
interface regfile_np_if
   import regfile_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int A = A_DEF
);

   logic         we;
   logic [A-1:0] waddr;
   logic [N-1:0] wdata;
   logic [A-1:0] raddr1;
   logic [A-1:0] raddr2;
   logic [N-1:0] rdata1;
   logic [N-1:0] rdata2;
   logic         clr_req;
   logic         busy;
   logic         clr_done;

   modport master (
      output we, waddr, wdata, raddr1, raddr2, clr_req,
      input  rdata1, rdata2, busy, clr_done
   );

   modport slave (
      input  we, waddr, wdata, raddr1, raddr2, clr_req,
      output rdata1, rdata2, busy, clr_done
   );

endinterface

// File: rtl/regfile_clr_seq.sv
// -----------------------------------------------------------------------------
// regfile_clr_seq
// Clear sequencer: walks an index over registers 1 .. 2^A-1, one per clock,
// then pulses clr_done for a single cycle.
//   clk, reset : clock, asynchronous active-high reset
//   clr_req    : start request, honoured only in IDLE
//   busy       : high exactly while the walk runs (2^A-1 cycles)
//   clr_done   : high exactly for the cycle after the walk
//   clr_we     : zero-write strobe to the storage array
//   clr_idx    : register being zeroed this cycle
// -----------------------------------------------------------------------------
module regfile_clr_seq
   import regfile_pkg::*;
#(
   parameter int A = A_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_req,
   output logic         busy,
   output logic         clr_done,
   output logic         clr_we,
   output logic [A-1:0] clr_idx
);

   localparam logic [A-1:0] IDX_FIRST = A'(1);
   localparam logic [A-1:0] IDX_LAST  = '1;   // 2^A-1, reached before the counter could wrap

   clr_state_t   state;
   logic [A-1:0] idx;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         busy     <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clr_req) begin
                  state <= CLEAR;
                  idx   <= IDX_FIRST;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               if (idx == IDX_LAST) begin
                  state    <= DONE;
                  idx      <= '0;
                  busy     <= 1'b0;
                  clr_done <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               clr_done <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               idx      <= '0;
               busy     <= 1'b0;
               clr_done <= 1'b0;
            end
         endcase
      end
   end

   // busy is registered and high only in CLEAR, so it doubles as the strobe.
   assign clr_we  = busy;
   assign clr_idx = idx;

endmodule

// File: rtl/regfile_np.sv
// -----------------------------------------------------------------------------
// regfile_np
// 2^A x N register file, one write port, two combinational read ports,
// register 0 hard-wired to zero, optional write-to-read forwarding and a
// sequenced whole-file clear.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : regfile_np_if.slave (write port, read ports, clear control)
// Parameters: N data width, A address width, BYPASS 1 = forward write data.
// -----------------------------------------------------------------------------
module regfile_np
   import regfile_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int A      = A_DEF,
   parameter int BYPASS = 1
) (
   input  logic         clk,
   input  logic         reset,
   regfile_np_if.slave  bus
);

   localparam int R = 2 ** A;

   logic [N-1:0] gpr [R];
   logic         busy;
   logic         clr_done;
   logic         clr_we;
   logic [A-1:0] clr_idx;
   logic         wr_en;

   regfile_clr_seq #(.A(A)) u_clr_seq (
      .clk      (clk),
      .reset    (reset),
      .clr_req  (bus.clr_req),
      .busy     (busy),
      .clr_done (clr_done),
      .clr_we   (clr_we),
      .clr_idx  (clr_idx)
   );

   assign bus.busy     = busy;
   assign bus.clr_done = clr_done;

   // External writes are dropped (not retried) while the clear runs.
   assign wr_en = bus.we && !busy && (bus.waddr != '0);

   // NOTE: the array is reset explicitly because an asynchronous reset must
   // zero every register at once; this keeps it in flops rather than RAM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < R; i++) begin
            gpr[i] <= '0;
         end
      end else if (clr_we) begin
         gpr[clr_idx] <= '0;
      end else if (wr_en) begin
         gpr[bus.waddr] <= bus.wdata;
      end
   end

   function automatic logic [N-1:0] read_port(
      input logic [A-1:0] ra,
      input logic [N-1:0] stored,
      input logic         wen,
      input logic [A-1:0] wa,
      input logic [N-1:0] wd
   );
      if (ra == '0) begin
         return '0;
      end
      if ((BYPASS != 0) && wen && (wa == ra)) begin
         return wd;
      end
      return stored;
   endfunction

   assign bus.rdata1 = read_port(bus.raddr1, gpr[bus.raddr1], wr_en, bus.waddr, bus.wdata);
   assign bus.rdata2 = read_port(bus.raddr2, gpr[bus.raddr2], wr_en, bus.waddr, bus.wdata);

endmodule

// File: tb/tb_regfile_np.sv
// -----------------------------------------------------------------------------
// tb_regfile_np
// Bench for regfile_np: forwarding and non-forwarding 8x8 builds driven in
// lockstep against a timeline model, plus a 16x16 build.
// -----------------------------------------------------------------------------
module tb_regfile_np;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   regfile_np_if #(.N(8),  .A(3)) bus0 ();
   regfile_np_if #(.N(8),  .A(3)) bus1 ();
   regfile_np_if #(.N(16), .A(4)) bus2 ();

   regfile_np #(.N(8),  .A(3), .BYPASS(1)) u_byp   (.clk(clk), .reset(rst), .bus(bus0));
   regfile_np #(.N(8),  .A(3), .BYPASS(0)) u_nobyp (.clk(clk), .reset(rst), .bus(bus1));
   regfile_np #(.N(16), .A(4), .BYPASS(1)) u_wide  (.clk(clk), .reset(rst), .bus(bus2));

   int checks = 0;
   int errors = 0;

   // Reference model: register contents plus the number of edges since the
   // clear started (0 = no clear). Edge k after the start zeroes register k
   // (k = 1..7), busy is seen during ages 1..7, clr_done during age 8.
   logic [7:0] mem [8];
   int         age;

   logic       cur_we, cur_clr;
   logic [2:0] cur_wa, cur_r1, cur_r2;
   logic [7:0] cur_wd;
   logic       obs_busy, obs_done;
   int         busy_cnt, done_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic model_busy();
      return (age >= 1) && (age <= 7);
   endfunction

   function automatic logic [7:0] exp_rd(input logic [2:0] ra, input bit byp);
      if (ra == 3'd0) return 8'h00;
      if (byp && cur_we && !model_busy() && cur_wa != 3'd0 && cur_wa == ra) return cur_wd;
      return mem[ra];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      age = 0;
   endtask

   task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic [2:0] r1, input logic [2:0] r2, input logic clr);
      cur_we = we; cur_wa = wa; cur_wd = wd; cur_r1 = r1; cur_r2 = r2; cur_clr = clr;
      bus0.we = we; bus0.waddr = wa; bus0.wdata = wd;
      bus0.raddr1 = r1; bus0.raddr2 = r2; bus0.clr_req = clr;
      bus1.we = we; bus1.waddr = wa; bus1.wdata = wd;
      bus1.raddr1 = r1; bus1.raddr2 = r2; bus1.clr_req = clr;
      #1;
   endtask

   // Compare both 8-bit builds with the model, clock one edge, advance model.
   task automatic tick();
      check("byp_rdata1",   bus0.rdata1,   exp_rd(cur_r1, 1'b1));
      check("byp_rdata2",   bus0.rdata2,   exp_rd(cur_r2, 1'b1));
      check("byp_busy",     bus0.busy,     model_busy());
      check("byp_done",     bus0.clr_done, age == 8);
      check("nobyp_rdata1", bus1.rdata1,   exp_rd(cur_r1, 1'b0));
      check("nobyp_rdata2", bus1.rdata2,   exp_rd(cur_r2, 1'b0));
      check("nobyp_busy",   bus1.busy,     model_busy());
      check("nobyp_done",   bus1.clr_done, age == 8);
      obs_busy = bus0.busy;
      obs_done = bus0.clr_done;
      @(posedge clk);
      if (model_busy()) mem[age] = 8'h00;
      else if (cur_we && cur_wa != 3'd0) mem[cur_wa] = cur_wd;
      if (age == 0) age = cur_clr ? 1 : 0;
      else if (age == 8) age = 0;
      else age++;
      @(negedge clk);
   endtask

   task automatic idle(input logic [2:0] r1, input logic [2:0] r2);
      drive(1'b0, 3'd0, 8'h00, r1, r2, 1'b0);
   endtask

   task automatic fill_all();
      for (int k = 1; k < 8; k++) begin
         drive(1'b1, 3'(k), 8'(k * 8'h11), 3'(k), 3'd0, 1'b0);
         tick();
      end
   endtask

   function automatic logic [15:0] val16(input int k);
      return 16'(k * 32'h1111) ^ 16'h0F0F;
   endfunction

   initial begin
      rst = 1'b1;
      bus2.we = 1'b0; bus2.waddr = '0; bus2.wdata = '0;
      bus2.raddr1 = '0; bus2.raddr2 = '0; bus2.clr_req = 1'b0;
      model_reset();
      idle(3'd3, 3'd7);

      // Reset state
      check("rst_busy",   bus0.busy,     1'b0);
      check("rst_done",   bus0.clr_done, 1'b0);
      check("rst_rdata1", bus0.rdata1,   8'h00);
      check("rst_rdata2", bus1.rdata2,   8'h00);
      check("rst_wide_busy", bus2.busy,  1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Scenario 1: first write right after reset; r0 ignores writes
      drive(1'b1, 3'd3, 8'hA5, 3'd3, 3'd0, 1'b0); tick();
      idle(3'd3, 3'd3);
      check("s1_r3_byp",   bus0.rdata1, 8'hA5);
      check("s1_r3_nobyp", bus1.rdata1, 8'hA5);
      tick();
      drive(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b0); tick();
      idle(3'd0, 3'd0);
      check("s1_r0", bus0.rdata1, 8'h00);
      tick();

      // Scenario 2: forwarding vs old value
      drive(1'b1, 3'd5, 8'h11, 3'd0, 3'd5, 1'b0); tick();
      drive(1'b1, 3'd5, 8'h3C, 3'd0, 3'd5, 1'b0);
      check("s2_bypass",   bus0.rdata2, 8'h3C);
      check("s2_nobypass", bus1.rdata2, 8'h11);
      tick();
      idle(3'd5, 3'd5);
      check("s2_commit", bus1.rdata2, 8'h3C);
      tick();

      // Scenario 3: full clear
      fill_all();
      drive(1'b0, 3'd0, 8'h00, 3'd1, 3'd7, 1'b1); tick();
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         idle(3'(i % 8), 3'(7 - i % 8)); tick();
         busy_cnt += int'(obs_busy);
         done_cnt += int'(obs_done);
      end
      check("s3_busy_cycles", busy_cnt, 7);
      check("s3_done_cycles", done_cnt, 1);
      for (int k = 0; k < 8; k++) begin
         idle(3'(k), 3'(7 - k));
         check("s3_zero", bus0.rdata1, 8'h00);
         tick();
      end

      // Scenario 4: write and clr_req during the clear are dropped
      drive(1'b1, 3'd2, 8'h5A, 3'd2, 3'd0, 1'b0); tick();
      drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd0, 1'b1); tick();
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) begin
            drive(1'b1, 3'd2, 8'h77, 3'd2, 3'd2, 1'b1);
            check("s4_no_bypass_busy", bus0.rdata1, 8'h5A);
         end else begin
            drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd2, i == 7);
         end
         tick();
         busy_cnt += int'(obs_busy);
         done_cnt += int'(obs_done);
      end
      check("s4_busy_cycles", busy_cnt, 7);
      check("s4_done_cycles", done_cnt, 1);
      idle(3'd2, 3'd2);
      check("s4_r2_zero", bus0.rdata1, 8'h00);
      tick();

      // Scenario 5: asynchronous reset with idx = 4
      fill_all();
      drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1); tick();
      for (int i = 0; i < 3; i++) begin
         idle(3'd4, 3'd3); tick();
      end
      idle(3'd4, 3'd3);
      check("s5_r4_kept",   bus0.rdata1, 8'h44);
      check("s5_r3_zeroed", bus0.rdata2, 8'h00);
      check("s5_busy_pre",  bus0.busy,   1'b1);
      #1 rst = 1'b1;
      #1;
      model_reset();
      check("s5_busy_byp",   bus0.busy,     1'b0);
      check("s5_busy_nobyp", bus1.busy,     1'b0);
      check("s5_done",       bus0.clr_done, 1'b0);
      for (int k = 1; k < 8; k++) begin
         idle(3'(k), 3'(k));
         check("s5_reg_zero", bus0.rdata1, 8'h00);
      end
      @(negedge clk);
      check("s5_done_held", bus0.clr_done, 1'b0);
      rst = 1'b0;
      drive(1'b1, 3'd6, 8'h6E, 3'd0, 3'd0, 1'b0); tick();
      idle(3'd6, 3'd4);
      check("s5_first_write", bus1.rdata1, 8'h6E);
      tick();
      for (int i = 0; i < 10; i++) begin
         idle(3'(i % 8), 3'd6); tick();
      end

      // Randomised traffic including clears, forwarding hits and r0 writes
      for (int i = 0; i < 300; i++) begin
         logic [2:0] wa;
         wa = 3'($urandom_range(0, 7));
         drive(1'($urandom_range(0, 1)), wa, 8'($urandom),
               ($urandom_range(0, 1) == 1) ? wa : 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), $urandom_range(0, 15) == 0);
         tick();
      end
      idle(3'd0, 3'd0);

      // Scenario 6: 16-bit data, 16 registers
      for (int k = 1; k < 16; k++) begin
         bus2.we = 1'b1; bus2.waddr = 4'(k); bus2.wdata = val16(k);
         @(posedge clk); @(negedge clk);
      end
      bus2.waddr = 4'd0; bus2.wdata = 16'hFFFF;
      @(posedge clk); @(negedge clk);
      bus2.we = 1'b0;
      for (int k = 0; k < 16; k++) begin
         bus2.raddr1 = 4'(k); bus2.raddr2 = 4'(15 - k);
         #1;
         check("s6_rd1", bus2.rdata1, (k == 0) ? 16'h0000 : val16(k));
         check("s6_rd2", bus2.rdata2, (k == 15) ? 16'h0000 : val16(15 - k));
      end
      @(negedge clk);
      bus2.clr_req = 1'b1;
      @(posedge clk); @(negedge clk);
      bus2.clr_req = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         busy_cnt += int'(bus2.busy);
         done_cnt += int'(bus2.clr_done);
         @(posedge clk); @(negedge clk);
      end
      check("s6_busy_cycles", busy_cnt, 15);
      check("s6_done_cycles", done_cnt, 1);
      for (int k = 1; k < 16; k++) begin
         bus2.raddr1 = 4'(k); bus2.raddr2 = 4'(16 - k);
         #1;
         check("s6_zero1", bus2.rdata1, 16'h0000);
         check("s6_zero2", bus2.rdata2, 16'h0000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_np.md
REGFILE_NP -- requirements
Module: regfile_np

Interface
REQ-001 Parameter N, default 8: data width in bits, N >= 1.
REQ-002 Parameter A, default 3: address width; register count 2^A, A >= 1.
REQ-003 Parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 we  input  1  write enable for the dedicated write port.
REQ-007 waddr  input  A  write destination address.
REQ-008 wdata  input  N  write data.
REQ-009 raddr1, raddr2  input  A each  read port addresses.
REQ-010 rdata1, rdata2  output  N each  combinational read data.
REQ-011 clr_req  input  1  request to zero the whole file.
REQ-012 busy  output  1  high while the clear sequence runs.
REQ-013 clr_done  output  1  one-cycle pulse when the clear sequence completes.

Function
REQ-014 Register 0 SHALL always read as zero; writes addressed to 0 SHALL be discarded.
REQ-015 Write: when we=1, waddr!=0 and busy=0 at a rising edge, gpr[waddr] SHALL take wdata at that edge.
REQ-016 Reads SHALL be combinational: rdataK = gpr[raddrK], or zero when raddrK=0.
REQ-017 When BYPASS=1, we=1, busy=0, waddr!=0 and waddr=raddrK, rdataK SHALL equal wdata in the same cycle.
REQ-018 When BYPASS=0, rdataK SHALL show the old value until the edge that commits the write.
REQ-019 Clear FSM states: IDLE, CLEAR, DONE.
REQ-020 IDLE -> CLEAR on a rising edge with clr_req=1; index counter loads 1.
REQ-021 In CLEAR, each edge SHALL zero gpr[idx] and increment idx; when idx = 2^A-1 the next state SHALL be DONE.
REQ-022 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-023 busy SHALL be 1 exactly in CLEAR: 2^A-1 cycles, 7 for A=3.
REQ-024 clr_done SHALL be 1 exactly in DONE.
REQ-025 External writes while busy=1 SHALL be dropped with no retry, and bypass SHALL be suppressed.
REQ-026 clr_req while in CLEAR or DONE SHALL be ignored and not queued.
REQ-027 In IDLE with clr_req=1 and a valid write on the same edge, the write SHALL commit, and the clear SHALL start on that edge and zero it later.
REQ-028 Reads during CLEAR SHALL return current contents: zero for indices below idx, old values otherwise.
REQ-029 The counter SHALL be A bits wide and SHALL never wrap; DONE is entered before overflow.

Reset
REQ-030 Asserting reset SHALL immediately zero all registers, set the FSM to IDLE, idx=0, busy=0 and clr_done=0, independent of clk.
REQ-031 Reset during CLEAR SHALL abort the sequence with no clr_done pulse.
REQ-032 The first write SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-033 Shared package regfile_pkg SHALL hold the clr_state_t enum (IDLE, CLEAR, DONE) and the default constants for N and A.
REQ-034 The FSM and counter SHALL live in sub-module regfile_clr_seq (ports: clk, reset, clr_req, busy, clr_done, clr_we, clr_idx); the storage array and read muxes stay in regfile_np.

Verification
REQ-035 Scenario 1: write 8'hA5 to r3, then read r3 on port 1 -> rdata1=8'hA5; write 8'hFF to r0 -> r0 reads 0.
REQ-036 Scenario 2: BYPASS=1, we=1, waddr=5, wdata=8'h3C, raddr2=5 in the same cycle -> rdata2=8'h3C before the edge; with BYPASS=0, old value shown.
REQ-037 Scenario 3: fill r1..r7 with nonzero values, pulse clr_req -> busy high for 7 cycles, clr_done for 1 cycle, then all reads return 0.
REQ-038 Scenario 4: write to r2 during busy -> dropped, r2=0 after DONE; clr_req during busy -> no second sequence.
REQ-039 Scenario 5: assert reset asynchronously mid-CLEAR (idx=4) -> busy=0 immediately, no clr_done, all registers 0.
REQ-040 Scenario 6: N=16, A=4 build -> busy high for 15 cycles, full 16-bit data round-trips on both ports.
